// File: rtl/cla_share_arbiter.sv
// cla_share_arbiter
//   Round-robin arbiter that time-shares one external registered CLA among
//   NUM_REQ requesters. A winner's operands are latched onto the CLA inputs
//   at the grant edge. The result is captured CLA_LATENCY edges later and
//   returned to the winner with a one-cycle done pulse.
//   Optional build macro CLA_SHARE_CHECK_EN adds a sticky result checker
//   (chk_err). When it is undefined, chk_err is tied low.
module cla_share_arbiter #(
    parameter int WIDTH       = 4,
    parameter int NUM_REQ     = 4,
    parameter int CLA_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_c0,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         rsp_s,
    output logic                     rsp_cout,
    output logic                     busy,
    output logic [WIDTH-1:0]         cla_a,
    output logic [WIDTH-1:0]         cla_b,
    output logic                     cla_c0,
    input  logic [WIDTH-1:0]         cla_s,
    input  logic                     cla_cout,
    output logic                     chk_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (CLA_LATENCY > 1) ? $clog2(CLA_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     idx;
    logic              any_req;
    logic [CW-1:0]     cnt;
    logic              grant_fire;
    logic              capture_fire;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              sel_c0;

    // Round-robin search: scan from rr_ptr downwards in priority so the
    // requester closest to rr_ptr is the last (winning) assignment.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    // Operand mux selecting the winner's slice.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_c0 = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PW'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_c0 = req_c0[i];
            end
        end
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state and one-cycle control strobes.
    always_comb begin
        state_nxt    = state;
        grant_fire   = 1'b0;
        capture_fire = 1'b0;
        case (state)
            IDLE: if (any_req) begin
                grant_fire = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: if (cnt == '0) begin
                capture_fire = 1'b1;
                state_nxt    = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant latching, latency counter, result capture, release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt      <= '0;
            done     <= '0;
            rsp_s    <= '0;
            rsp_cout <= 1'b0;
            cla_a    <= '0;
            cla_b    <= '0;
            cla_c0   <= 1'b0;
            rr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (grant_fire) begin
                cla_a  <= sel_a;
                cla_b  <= sel_b;
                cla_c0 <= sel_c0;
                gnt    <= NUM_REQ'(1) << win;
                rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
                cnt    <= CW'(CLA_LATENCY - 1);
            end else if (state == WAIT && !capture_fire) begin
                cnt <= cnt - CW'(1);
            end
            if (capture_fire) begin
                rsp_s    <= cla_s;
                rsp_cout <= cla_cout;
                done     <= gnt;
            end
            if (state == RESP) begin
                done <= '0;
                gnt  <= '0;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef CLA_SHARE_CHECK_EN
    localparam int SW = WIDTH + 1;
    logic [WIDTH:0] expected;

    // Reference sum latched at grant, compared against the CLA at capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expected <= '0;
            chk_err  <= 1'b0;
        end else begin
            if (grant_fire)
                expected <= {1'b0, sel_a} + {1'b0, sel_b} + SW'(sel_c0);
            if (capture_fire && ({cla_cout, cla_s} != expected))
                chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Directed testbench for cla_share_arbiter (WIDTH=4, NUM_REQ=4, CLA_LATENCY=1).
// The CLA is modelled as a combinational adder with an injectable +1 fault.
module tb_cla_share_arbiter;

    localparam int W = 4;
    localparam int N = 4;
    localparam int L = 1;
`ifdef CLA_SHARE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_c0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   rsp_s;
    logic           rsp_cout;
    logic           busy;
    logic [W-1:0]   cla_a;
    logic [W-1:0]   cla_b;
    logic           cla_c0;
    logic [W-1:0]   cla_s;
    logic           cla_cout;
    logic           chk_err;
    logic           fault;

    int total = 0;
    int bad   = 0;

    cla_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .CLA_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .req_c0(req_c0), .gnt(gnt), .done(done), .rsp_s(rsp_s),
        .rsp_cout(rsp_cout), .busy(busy), .cla_a(cla_a), .cla_b(cla_b),
        .cla_c0(cla_c0), .cla_s(cla_s), .cla_cout(cla_cout), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    // External CLA model; fault adds one to the true sum.
    assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + 5'(cla_c0) + 5'(fault);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N-1:0] seen;
        reset = 1'b0; req = '0; req_a = '0; req_b = '0; req_c0 = '0; fault = 1'b0;
        tick(); tick();
        total++; if ({gnt, done, rsp_s, rsp_cout, busy, cla_a, cla_b, cla_c0, chk_err} !== '0) begin bad++; $display("FAIL reset_outputs: got gnt=%b done=%b s=%0d busy=%b cla_a=%0d want all zero", gnt, done, rsp_s, busy, cla_a); end
        reset = 1'b1;
        tick();
        req = 4'b0001; req_a = 16'h0006; req_b = 16'h0006;
        tick();
        total++; if ({busy, gnt} !== 5'b1_0001) begin bad++; $display("FAIL reset_pre_grant: got busy=%b gnt=%b want busy=1 gnt=0001", busy, gnt); end
        reset = 1'b0;
        #1;
        total++; if ({gnt, done, rsp_s, rsp_cout, busy, cla_a, cla_b, cla_c0, chk_err} !== '0) begin bad++; $display("FAIL reset_mid_wait: got gnt=%b done=%b s=%0d busy=%b cla_a=%0d want all zero", gnt, done, rsp_s, busy, cla_a); end
        req = '0;
        seen = '0;
        tick(); seen |= done;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); seen |= done;
        end
        total++; if (seen !== 4'b0000) begin bad++; $display("FAIL reset_no_done: got done seen=%b want 0000", seen); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_single_op();
        req = 4'b0001; req_a = 16'h000D; req_b = 16'h0007; req_c0 = 4'b0001;
        tick();
        total++; if ({cla_a, cla_b, cla_c0} !== {4'd13, 4'd7, 1'b1}) begin bad++; $display("FAIL single_operands: got a=%0d b=%0d c0=%b want 13 7 1", cla_a, cla_b, cla_c0); end
        total++; if ({gnt, done, busy} !== {4'b0001, 4'b0000, 1'b1}) begin bad++; $display("FAIL single_grant: got gnt=%b done=%b busy=%b want 0001 0000 1", gnt, done, busy); end
        tick();
        total++; if ({done, gnt} !== {4'b0001, 4'b0001}) begin bad++; $display("FAIL single_done: got done=%b gnt=%b want 0001 0001", done, gnt); end
        total++; if ({rsp_cout, rsp_s} !== {1'b1, 4'd5}) begin bad++; $display("FAIL single_result: got cout=%b s=%0d want 1 5", rsp_cout, rsp_s); end
        req = '0;
        tick();
        total++; if ({gnt, done, busy} !== '0) begin bad++; $display("FAIL single_release: got gnt=%b done=%b busy=%b want zeros", gnt, done, busy); end
        total++; if ({rsp_cout, rsp_s} !== {1'b1, 4'd5}) begin bad++; $display("FAIL single_hold: got cout=%b s=%0d want 1 5", rsp_cout, rsp_s); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_a [N] = '{4'd3, 4'd7, 4'd11, 4'd15};
        logic [W-1:0] exp_s [N] = '{4'd8, 4'd0, 4'd6, 4'd14};
        logic         exp_c [N] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int g;
        reset = 1'b0; #1; reset = 1'b1;
        tick();
        req_a = 16'hFB73; req_b = 16'hEB85; req_c0 = 4'b1010; req = 4'b1111;
        for (int op = 0; op < 5; op++) begin
            g = op % N;
            tick();
            total++; if ({gnt, cla_a} !== {4'b0001 << g, exp_a[g]}) begin bad++; $display("FAIL rr_grant%0d: got gnt=%b a=%0d want gnt=%b a=%0d", op, gnt, cla_a, 4'b0001 << g, exp_a[g]); end
            tick();
            total++; if ({done, rsp_cout, rsp_s} !== {4'b0001 << g, exp_c[g], exp_s[g]}) begin bad++; $display("FAIL rr_done%0d: got done=%b cout=%b s=%0d want %b %b %0d", op, done, rsp_cout, rsp_s, 4'b0001 << g, exp_c[g], exp_s[g]); end
            tick();
            total++; if ({gnt, done, busy} !== '0) begin bad++; $display("FAIL rr_gap%0d: got gnt=%b done=%b busy=%b want zeros", op, gnt, done, busy); end
        end
        req = '0;
    endtask

    task automatic test_wrap();
        req = 4'b0100;
        tick(); tick();
        req = '0;
        tick();
        req = 4'b1001;
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL wrap_first: got gnt=%b want 1000", gnt); end
        tick();
        total++; if ({done, rsp_s} !== {4'b1000, 4'd14}) begin bad++; $display("FAIL wrap_first_done: got done=%b s=%0d want 1000 14", done, rsp_s); end
        req = 4'b0001;
        tick();
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wrap_second: got gnt=%b want 0001", gnt); end
        tick();
        total++; if ({done, rsp_s, rsp_cout} !== {4'b0001, 4'd8, 1'b0}) begin bad++; $display("FAIL wrap_second_done: got done=%b s=%0d cout=%b want 0001 8 0", done, rsp_s, rsp_cout); end
        req = '0;
        tick();
    endtask

    task automatic test_operand_change();
        req = 4'b0010; req_a = 16'h0090; req_b = 16'h0030; req_c0 = 4'b0000;
        tick();
        total++; if ({gnt, cla_a, cla_b} !== {4'b0010, 4'd9, 4'd3}) begin bad++; $display("FAIL opchg_grant: got gnt=%b a=%0d b=%0d want 0010 9 3", gnt, cla_a, cla_b); end
        req_a = 16'hFFFF; req_b = 16'hFFFF; req_c0 = 4'hF; req = '0;
        #1;
        total++; if ({cla_a, cla_b, cla_c0} !== {4'd9, 4'd3, 1'b0}) begin bad++; $display("FAIL opchg_stable: got a=%0d b=%0d c0=%b want 9 3 0", cla_a, cla_b, cla_c0); end
        tick();
        total++; if ({done, rsp_cout, rsp_s} !== {4'b0010, 1'b0, 4'd12}) begin bad++; $display("FAIL opchg_done: got done=%b cout=%b s=%0d want 0010 0 12", done, rsp_cout, rsp_s); end
        tick();
        total++; if ({gnt, done, busy} !== '0) begin bad++; $display("FAIL opchg_release: got gnt=%b done=%b busy=%b want zeros", gnt, done, busy); end
    endtask

    task automatic test_checker();
        total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_clean: got chk_err=%b want 0", chk_err); end
        fault = 1'b1; req = 4'b0001; req_a = 16'h0002; req_b = 16'h0003; req_c0 = 4'b0000;
        tick(); tick();
        total++; if ({done, rsp_s} !== {4'b0001, 4'd6}) begin bad++; $display("FAIL chk_transport: got done=%b s=%0d want 0001 6", done, rsp_s); end
        req = '0; fault = 1'b0;
        tick();
        total++; if (chk_err !== EXP_ERR) begin bad++; $display("FAIL chk_flag: got chk_err=%b want %b", chk_err, EXP_ERR); end
        req = 4'b0001;
        tick(); tick();
        req = '0;
        tick(); tick();
        total++; if (chk_err !== EXP_ERR) begin bad++; $display("FAIL chk_sticky: got chk_err=%b want %b", chk_err, EXP_ERR); end
        total++; if ({rsp_cout, rsp_s} !== {1'b0, 4'd5}) begin bad++; $display("FAIL chk_good_result: got cout=%b s=%0d want 0 5", rsp_cout, rsp_s); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_wrap();
        test_operand_change();
        test_checker();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
